// File: rtl/nrx_pkg.sv
// rtl/nrx_pkg.sv - shared types and default ROM image layout for the NRX core
// Contents:
//   ldr_state_t          loader state machine encoding
//   RGN_CPU..RGN_PAL     bit index of each region in the one-hot write strobe
//   NRX_B1..NRX_TOTAL    default region bounds and exact image length (bytes)
package nrx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } ldr_state_t;

    localparam int RGN_CPU = 0;
    localparam int RGN_GFX = 1;
    localparam int RGN_SND = 2;
    localparam int RGN_PAL = 3;

    localparam logic [24:0] NRX_B1    = 25'h04000;
    localparam logic [24:0] NRX_B2    = 25'h06000;
    localparam logic [24:0] NRX_B3    = 25'h06100;
    localparam logic [24:0] NRX_TOTAL = 25'h06200;

endpackage

// File: rtl/rgn_decode.sv
// rtl/rgn_decode.sv - flat byte address to (one-hot region, region offset) decoder
// Ports:
//   addr_i    flat image byte address
//   rgn_oh_o  one-hot region select, bit n = region n
//   offset_o  address relative to the selected region base
module rgn_decode
    import nrx_pkg::*;
#(
    parameter logic [24:0] B1 = NRX_B1,
    parameter logic [24:0] B2 = NRX_B2,
    parameter logic [24:0] B3 = NRX_B3
) (
    input  logic [24:0] addr_i,
    output logic [3:0]  rgn_oh_o,
    output logic [15:0] offset_o
);

    logic [24:0] base;

    always_comb begin
        rgn_oh_o = '0;
        base     = '0;
        if (addr_i < B1) begin
            rgn_oh_o[RGN_CPU] = 1'b1;
        end else if (addr_i < B2) begin
            rgn_oh_o[RGN_GFX] = 1'b1;
            base              = B1;
        end else if (addr_i < B3) begin
            rgn_oh_o[RGN_SND] = 1'b1;
            base              = B2;
        end else begin
            rgn_oh_o[RGN_PAL] = 1'b1;
            base              = B3;
        end
        offset_o = 16'(addr_i - base);
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// rtl/rom_load_sequencer.sv - ioctl ROM download demux, image check and core reset control
// Ports:
//   clk_sys, RESET_N       clock, synchronous active-low reset
//   ioctl_download/wr/addr/dout   byte stream from hps_io
//   user_rst               active-high OSD/button reset request
//   rom_we/rom_ad/rom_dt   per-region one-hot write strobe, region-relative address, data
//   core_reset             active-high reset to the game core
//   load_ok, load_err      valid image resident / last download malformed
module rom_load_sequencer
    import nrx_pkg::*;
#(
    parameter logic [24:0] B1     = NRX_B1,
    parameter logic [24:0] B2     = NRX_B2,
    parameter logic [24:0] B3     = NRX_B3,
    parameter logic [24:0] TOTAL  = NRX_TOTAL,
    parameter int          SETTLE = 16
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_rst,
    output logic [3:0]  rom_we,
    output logic [15:0] rom_ad,
    output logic [7:0]  rom_dt,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    ldr_state_t  state_q, state_d;
    logic        dl_q;
    logic [24:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] scnt_q, scnt_d;
    logic [3:0]  rom_we_q, rom_we_d;
    logic [15:0] rom_ad_q, rom_ad_d;
    logic [7:0]  rom_dt_q, rom_dt_d;
    logic        core_reset_q, core_reset_d;
    logic        load_ok_q, load_ok_d;
    logic        load_err_q, load_err_d;

    logic        dl_rise, dl_fall;
    logic        wr_ok, wr_bad;
    logic [24:0] cnt_acc;
    logic        err_acc;
    logic [3:0]  rgn_oh;
    logic [15:0] rgn_off;

    rgn_decode #(
        .B1(B1),
        .B2(B2),
        .B3(B3)
    ) u_rgn_decode (
        .addr_i  (ioctl_addr),
        .rgn_oh_o(rgn_oh),
        .offset_o(rgn_off)
    );

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    // A byte is accepted only if it is the next one in sequence and inside the image.
    assign wr_ok   = (state_q == ST_LOAD) && ioctl_wr && (ioctl_addr == cnt_q) && (ioctl_addr < TOTAL);
    assign wr_bad  = (state_q == ST_LOAD) && ioctl_wr && !wr_ok;
    // Count/error including this cycle's byte, so a write coinciding with the
    // falling download edge still counts toward completeness.
    assign cnt_acc = wr_ok ? cnt_q + 25'd1 : cnt_q;
    assign err_acc = err_q | wr_bad;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        scnt_d     = scnt_q;
        rom_we_d   = '0;
        rom_ad_d   = rom_ad_q;
        rom_dt_d   = rom_dt_q;
        load_ok_d  = load_ok_q;
        load_err_d = load_err_q;

        case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                cnt_d = cnt_acc;
                err_d = err_acc;
                if (wr_ok) begin
                    rom_we_d = rgn_oh;
                    rom_ad_d = rgn_off;
                    rom_dt_d = ioctl_dout;
                end
                if (dl_fall) begin
                    if (!err_acc && (cnt_acc == TOTAL)) begin
                        state_d = ST_SETTLE;
                        scnt_d  = '0;
                    end else begin
                        state_d    = ST_ERROR;
                        load_err_d = 1'b1;
                        load_ok_d  = 1'b0;
                    end
                end
            end
            ST_SETTLE: begin
                if (user_rst) begin
                    scnt_d = '0;
                end else if (scnt_q == SETTLE_LAST) begin
                    state_d   = ST_RUN;
                    load_ok_d = 1'b1;
                end else begin
                    scnt_d = scnt_q + 16'd1;
                end
            end
            ST_RUN: begin
                if (user_rst) begin
                    state_d = ST_SETTLE;
                    scnt_d  = '0;
                end
            end
            ST_ERROR: ;
            default: state_d = ST_IDLE;
        endcase

        // A new download always restarts loading, whatever the current state.
        if (dl_rise) begin
            state_d    = ST_LOAD;
            cnt_d      = '0;
            err_d      = 1'b0;
            load_ok_d  = 1'b0;
            load_err_d = 1'b0;
        end

        // Registered from the next state so core_reset moves with the state itself.
        core_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            // Seeded high so a download still active across reset is not seen
            // as a new rising edge; the host must start a fresh download.
            dl_q         <= 1'b1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            scnt_q       <= '0;
            rom_we_q     <= '0;
            rom_ad_q     <= '0;
            rom_dt_q     <= '0;
            core_reset_q <= 1'b1;
            load_ok_q    <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dl_q         <= ioctl_download;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            scnt_q       <= scnt_d;
            rom_we_q     <= rom_we_d;
            rom_ad_q     <= rom_ad_d;
            rom_dt_q     <= rom_dt_d;
            core_reset_q <= core_reset_d;
            load_ok_q    <= load_ok_d;
            load_err_q   <= load_err_d;
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_ad     = rom_ad_q;
    assign rom_dt     = rom_dt_q;
    assign core_reset = core_reset_q;
    assign load_ok    = load_ok_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb/tb_rom_load_sequencer.sv - directed self-checking bench for rom_load_sequencer
module tb_rom_load_sequencer;

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_rst;
    logic [3:0]  rom_we;
    logic [15:0] rom_ad;
    logic [7:0]  rom_dt;
    logic        core_reset;
    logic        load_ok;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected {rom_we, rom_ad, rom_dt} pulses, filled by the stimulus.
    logic [27:0] exp_q[$];
    int          wr_bad = 0;
    int          we_cnt[4];
    int          we_base[4];
    int          we_exp[4];

    rom_load_sequencer dut (
        .clk_sys       (clk_sys),
        .RESET_N       (RESET_N),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .user_rst      (user_rst),
        .rom_we        (rom_we),
        .rom_ad        (rom_ad),
        .rom_dt        (rom_dt),
        .core_reset    (core_reset),
        .load_ok       (load_ok),
        .load_err      (load_err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        for (int i = 0; i < 4; i++) we_cnt[i] = 0;
    end

    always @(negedge clk_sys) begin
        if (rom_we !== 4'b0000) begin
            for (int i = 0; i < 4; i++) if (rom_we[i] === 1'b1) we_cnt[i] = we_cnt[i] + 1;
            if (exp_q.size() == 0) begin
                wr_bad = wr_bad + 1;
            end else if (exp_q.pop_front() !== {rom_we, rom_ad, rom_dt}) begin
                wr_bad = wr_bad + 1;
            end
        end
    end

    function automatic logic [7:0] data_of(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ 8'h5A;
    endfunction

    // Hand-coded image map: CPU 0..3FFF, GFX 4000..5FFF, SND 6000..60FF, PAL 6100..61FF.
    function automatic logic [27:0] exp_word(input int a);
        logic [3:0]  oh;
        logic [31:0] off;
        if (a < 'h4000)      begin oh = 4'b0001; off = a; end
        else if (a < 'h6000) begin oh = 4'b0010; off = a - 'h4000; end
        else if (a < 'h6100) begin oh = 4'b0100; off = a - 'h6000; end
        else                 begin oh = 4'b1000; off = a - 'h6100; end
        return {oh, off[15:0], data_of(a)};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int a, input bit accept);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = data_of(a);
        if (accept) exp_q.push_back(exp_word(a));
        tick();
    endtask

    task automatic send_range(input int first, input int last);
        for (int a = first; a <= last; a++) send(a, 1'b1);
    endtask

    task automatic end_download();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        tick();
    endtask

    initial begin
        RESET_N        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        user_rst       = 1'b0;
        tick();
        tick();

        chk("rst_rom_we", 32'(rom_we), 32'h0);
        chk("rst_rom_ad", 32'(rom_ad), 32'h0);
        chk("rst_rom_dt", 32'(rom_dt), 32'h0);
        chk("rst_core_reset", 32'(core_reset), 32'h1);
        chk("rst_load_ok", 32'(load_ok), 32'h0);
        chk("rst_load_err", 32'(load_err), 32'h0);
        RESET_N = 1'b1;
        tick();

        // Nominal load
        for (int i = 0; i < 4; i++) we_base[i] = we_cnt[i];
        start_download();
        send(0, 1'b1);
        chk("nom_first_we", 32'(rom_we), 32'h1);
        send_range(1, 'h3FFF);
        send('h4000, 1'b1);
        chk("nom_gfx_we", 32'(rom_we), 32'h2);
        chk("nom_gfx_ad", 32'(rom_ad), 32'h0);
        send_range('h4001, 'h60FF);
        send('h6100, 1'b1);
        chk("nom_pal_we", 32'(rom_we), 32'h8);
        send_range('h6101, 'h61FF);
        end_download();
        chk("nom_hold_ad", 32'(rom_ad), 32'h00FF);
        chk("nom_hold_dt", 32'(rom_dt), 32'hA5);
        for (int i = 0; i < 15; i++) tick();
        chk("nom_settle_core_reset", 32'(core_reset), 32'h1);
        chk("nom_settle_load_ok", 32'(load_ok), 32'h0);
        tick();
        chk("nom_run_core_reset", 32'(core_reset), 32'h0);
        chk("nom_run_load_ok", 32'(load_ok), 32'h1);
        chk("nom_run_load_err", 32'(load_err), 32'h0);
        we_exp[0] = 'h4000; we_exp[1] = 'h2000; we_exp[2] = 'h100; we_exp[3] = 'h100;
        for (int i = 0; i < 4; i++) chk($sformatf("nom_we_count%0d", i), 32'(we_cnt[i] - we_base[i]), 32'(we_exp[i]));

        // User reset in RUN: 3-cycle pulse
        user_rst = 1'b1;
        tick();
        chk("urst_first_cycle", 32'(core_reset), 32'h1);
        tick();
        tick();
        user_rst = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("urst_still_held", 32'(core_reset), 32'h1);
        tick();
        chk("urst_released", 32'(core_reset), 32'h0);
        chk("urst_load_ok", 32'(load_ok), 32'h1);

        // Re-download mid-RUN, then RESET_N at byte 0x1000
        start_download();
        chk("redl_load_ok", 32'(load_ok), 32'h0);
        chk("redl_core_reset", 32'(core_reset), 32'h1);
        send_range(0, 'hFFF);
        RESET_N = 1'b0;
        send('h1000, 1'b0);
        chk("rstld_rom_we", 32'(rom_we), 32'h0);
        chk("rstld_rom_ad", 32'(rom_ad), 32'h0);
        chk("rstld_rom_dt", 32'(rom_dt), 32'h0);
        chk("rstld_core_reset", 32'(core_reset), 32'h1);
        chk("rstld_load_ok", 32'(load_ok), 32'h0);
        chk("rstld_load_err", 32'(load_err), 32'h0);
        RESET_N = 1'b1;
        for (int a = 'h1001; a <= 'h1004; a++) begin
            send(a, 1'b0);
            chk("rstld_no_we", 32'(rom_we), 32'h0);
        end
        end_download();
        tick();
        chk("rstld_idle_err", 32'(load_err), 32'h0);
        chk("rstld_idle_core_reset", 32'(core_reset), 32'h1);

        // Fresh download after reset
        start_download();
        send_range(0, 'h61FF);
        end_download();
        for (int i = 0; i < 16; i++) tick();
        chk("fresh_core_reset", 32'(core_reset), 32'h0);
        chk("fresh_load_ok", 32'(load_ok), 32'h1);

        // Short image (one byte missing)
        start_download();
        chk("short_start_load_ok", 32'(load_ok), 32'h0);
        send_range(0, 'h61FE);
        end_download();
        chk("short_load_err", 32'(load_err), 32'h1);
        chk("short_load_ok", 32'(load_ok), 32'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("short_core_reset", 32'(core_reset), 32'h1);

        // Address skip
        start_download();
        chk("skip_err_cleared", 32'(load_err), 32'h0);
        send_range(0, 'h10);
        send('h12, 1'b0);
        chk("skip_suppressed", 32'(rom_we), 32'h0);
        end_download();
        chk("skip_load_err", 32'(load_err), 32'h1);
        chk("skip_core_reset", 32'(core_reset), 32'h1);

        tick();
        tick();
        chk("sb_pending", 32'(exp_q.size()), 32'h0);
        chk("sb_bad_pulses", 32'(wr_bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
